pipe_id_ex: RTL and testbench

Pipeline register between the Instruction Decode (ID) and Execute (EX) stages of the 5-stage RISC-V-style core. On each rising clock edge it captures the decoded control signals, register addresses, register-file read data and immediate produced in ID, and presents them to EX for the next cycle. No stall or flush inputs; the only clear is the reset.

---
 rtl/pipe_id_ex_pkg.sv | 20 ++
 rtl/pipe_id_ex_if.sv | 48 ++++
 rtl/pipe_id_ex_pipe_reg.sv | 23 ++
 rtl/pipe_id_ex.sv | 56 +++++
 tb/tb_pipe_id_ex.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipe_id_ex_pkg.sv
// rtl/pipe_id_ex_pkg.sv - shared widths and control bundle for the ID/EX pipeline register
package pipe_id_ex_pkg;

    localparam int XLEN      = 32;
    localparam int ALUOP_W   = 4;
    localparam int REGADDR_W = 5;

    // Control bundle reused by the later pipeline registers (EX/MEM, MEM/WB).
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               memread;
    } id_ex_ctrl_t;

    localparam int CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/pipe_id_ex_if.sv
// rtl/pipe_id_ex_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface pipe_id_ex_if
    import pipe_id_ex_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic [ALUOP_W-1:0]   ALUOP_IN;
    logic                 ALUSRC_IN;
    logic                 REGWRITE_IN;
    logic                 MEMTOREG_IN;
    logic                 MEMWRITE_IN;
    logic                 MEMREAD_IN;
    logic [REGADDR_W-1:0] ARS1_IN;
    logic [REGADDR_W-1:0] ARS2_IN;
    logic [REGADDR_W-1:0] ARD_IN;
    logic [WIDTH-1:0]     RS1_IN;
    logic [WIDTH-1:0]     RS2_IN;
    logic [WIDTH-1:0]     IMMEDIATE_IN;

    logic [ALUOP_W-1:0]   ALUOP_OUT;
    logic                 ALUSRC_OUT;
    logic                 REGWRITE_OUT;
    logic                 MEMTOREG_OUT;
    logic                 MEMWRITE_OUT;
    logic                 MEMREAD_OUT;
    logic [REGADDR_W-1:0] ARS1_OUT;
    logic [REGADDR_W-1:0] ARS2_OUT;
    logic [REGADDR_W-1:0] ARD_OUT;
    logic [WIDTH-1:0]     RS1_OUT;
    logic [WIDTH-1:0]     RS2_OUT;
    logic [WIDTH-1:0]     IMMEDIATE_OUT;

    modport master (
        output ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
        output ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN,
        input  ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT,
        input  ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT, IMMEDIATE_OUT
    );

    modport slave (
        input  ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN,
        input  ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN, IMMEDIATE_IN,
        output ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT,
        output ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT, IMMEDIATE_OUT
    );

endinterface

// File: rtl/pipe_id_ex_pipe_reg.sv
// rtl/pipe_id_ex_pipe_reg.sv - parameterised D flop with synchronous active-low clear
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Clear wins over capture, so a cleared stage becomes a bubble.
    assign data_d = rstn_i ? d_i : '0;

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_id_ex.sv
// rtl/pipe_id_ex.sv - ID/EX pipeline register: one-cycle registered copy of the decode outputs
module pipe_id_ex
    import pipe_id_ex_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    pipe_id_ex_if.slave  bus
);

    localparam int BUS_W = CTRL_W + 3 * REGADDR_W + 3 * WIDTH;

    id_ex_ctrl_t          ctrl_d;
    id_ex_ctrl_t          ctrl_q;
    logic [REGADDR_W-1:0] ars1_q;
    logic [REGADDR_W-1:0] ars2_q;
    logic [REGADDR_W-1:0] ard_q;
    logic [WIDTH-1:0]     rs1_q;
    logic [WIDTH-1:0]     rs2_q;
    logic [WIDTH-1:0]     imm_q;
    logic [BUS_W-1:0]     stage_d;
    logic [BUS_W-1:0]     stage_q;

    assign ctrl_d = {bus.ALUOP_IN, bus.ALUSRC_IN, bus.REGWRITE_IN,
                     bus.MEMTOREG_IN, bus.MEMWRITE_IN, bus.MEMREAD_IN};

    // Whole stage is one flat bus so every field shares the same clear and timing.
    assign stage_d = {ctrl_d, bus.ARS1_IN, bus.ARS2_IN, bus.ARD_IN,
                      bus.RS1_IN, bus.RS2_IN, bus.IMMEDIATE_IN};

    pipe_reg #(
        .WIDTH (BUS_W)
    ) u_stage_reg (
        .clk_i  (clk),
        .rstn_i (rst),
        .d_i    (stage_d),
        .q_o    (stage_q)
    );

    assign {ctrl_q, ars1_q, ars2_q, ard_q, rs1_q, rs2_q, imm_q} = stage_q;

    assign bus.ALUOP_OUT     = ctrl_q.aluop;
    assign bus.ALUSRC_OUT    = ctrl_q.alusrc;
    assign bus.REGWRITE_OUT  = ctrl_q.regwrite;
    assign bus.MEMTOREG_OUT  = ctrl_q.memtoreg;
    assign bus.MEMWRITE_OUT  = ctrl_q.memwrite;
    assign bus.MEMREAD_OUT   = ctrl_q.memread;
    assign bus.ARS1_OUT      = ars1_q;
    assign bus.ARS2_OUT      = ars2_q;
    assign bus.ARD_OUT       = ard_q;
    assign bus.RS1_OUT       = rs1_q;
    assign bus.RS2_OUT       = rs2_q;
    assign bus.IMMEDIATE_OUT = imm_q;

endmodule

// File: tb/tb_pipe_id_ex.sv
// tb/tb_pipe_id_ex.sv - table-driven self-checking bench for pipe_id_ex
module tb_pipe_id_ex;

    typedef struct packed {
        logic [3:0]  aluop;
        logic        alusrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        memread;
        logic [4:0]  ars1;
        logic [4:0]  ars2;
        logic [4:0]  ard;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
    } fields_t;

    typedef struct packed {
        logic    rst;
        fields_t in;
        fields_t exp;
    } vec_t;

    localparam int NV = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t tbl [NV];

    fields_t zero_f, a_f, b_f, ones_f, c_f, d_f;

    pipe_id_ex_if #(.WIDTH(32)) bus ();

    pipe_id_ex #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input fields_t f);
        bus.ALUOP_IN     = f.aluop;
        bus.ALUSRC_IN    = f.alusrc;
        bus.REGWRITE_IN  = f.regwrite;
        bus.MEMTOREG_IN  = f.memtoreg;
        bus.MEMWRITE_IN  = f.memwrite;
        bus.MEMREAD_IN   = f.memread;
        bus.ARS1_IN      = f.ars1;
        bus.ARS2_IN      = f.ars2;
        bus.ARD_IN       = f.ard;
        bus.RS1_IN       = f.rs1;
        bus.RS2_IN       = f.rs2;
        bus.IMMEDIATE_IN = f.imm;
    endtask

    function automatic fields_t sample();
        fields_t f;
        f.aluop    = bus.ALUOP_OUT;
        f.alusrc   = bus.ALUSRC_OUT;
        f.regwrite = bus.REGWRITE_OUT;
        f.memtoreg = bus.MEMTOREG_OUT;
        f.memwrite = bus.MEMWRITE_OUT;
        f.memread  = bus.MEMREAD_OUT;
        f.ars1     = bus.ARS1_OUT;
        f.ars2     = bus.ARS2_OUT;
        f.ard      = bus.ARD_OUT;
        f.rs1      = bus.RS1_OUT;
        f.rs2      = bus.RS2_OUT;
        f.imm      = bus.IMMEDIATE_OUT;
        return f;
    endfunction

    task automatic check(input string name, input fields_t got, input fields_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        zero_f = '0;
        a_f    = '{aluop: 4'b1010, alusrc: 1'b1, regwrite: 1'b1, memtoreg: 1'b0,
                   memwrite: 1'b1, memread: 1'b0, ars1: 5'd1, ars2: 5'd2, ard: 5'd3,
                   rs1: 32'hAAAAAAAA, rs2: 32'h55555555, imm: 32'h12345678};
        b_f    = '{aluop: 4'b0101, alusrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b1,
                   memwrite: 1'b0, memread: 1'b1, ars1: 5'd4, ars2: 5'd5, ard: 5'd6,
                   rs1: 32'hFFFFFFFF, rs2: 32'h00000000, imm: 32'h87654321};
        ones_f = '{aluop: 4'hF, alusrc: 1'b1, regwrite: 1'b1, memtoreg: 1'b1,
                   memwrite: 1'b1, memread: 1'b1, ars1: 5'd31, ars2: 5'd31, ard: 5'd31,
                   rs1: 32'hFFFFFFFF, rs2: 32'hFFFFFFFF, imm: 32'hFFFFFFFF};
        c_f    = '{aluop: 4'b0000, alusrc: 1'b0, regwrite: 1'b1, memtoreg: 1'b0,
                   memwrite: 1'b0, memread: 1'b0, ars1: 5'd31, ars2: 5'd0, ard: 5'd31,
                   rs1: 32'h80000000, rs2: 32'h00000001, imm: 32'hFFFFF800};
        d_f    = '{aluop: 4'b1000, alusrc: 1'b1, regwrite: 1'b0, memtoreg: 1'b0,
                   memwrite: 1'b0, memread: 1'b1, ars1: 5'd16, ars2: 5'd15, ard: 5'd0,
                   rs1: 32'h0000FFFF, rs2: 32'hDEADBEEF, imm: 32'h00000800};

        tbl[0] = '{rst: 1'b0, in: zero_f, exp: zero_f};
        tbl[1] = '{rst: 1'b1, in: a_f,    exp: a_f};
        tbl[2] = '{rst: 1'b1, in: b_f,    exp: b_f};
        tbl[3] = '{rst: 1'b0, in: b_f,    exp: zero_f};
        tbl[4] = '{rst: 1'b1, in: a_f,    exp: a_f};
        tbl[5] = '{rst: 1'b1, in: ones_f, exp: ones_f};
        tbl[6] = '{rst: 1'b0, in: ones_f, exp: zero_f};
        tbl[7] = '{rst: 1'b1, in: c_f,    exp: c_f};
        tbl[8] = '{rst: 1'b1, in: d_f,    exp: d_f};
        tbl[9] = '{rst: 1'b1, in: zero_f, exp: zero_f};

        rst = 1'b0;
        drive(zero_f);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            drive(tbl[i].in);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end

        // Inputs changed right after an edge must not reach the outputs early.
        @(negedge clk);
        rst = 1'b1;
        drive(a_f);
        @(posedge clk);
        #1;
        check("hold_capture", sample(), a_f);
        drive(b_f);
        #1;
        check("hold_after_change", sample(), a_f);
        @(negedge clk);
        check("hold_at_negedge", sample(), a_f);
        @(posedge clk);
        #1;
        check("hold_next_edge", sample(), b_f);

        // A reset pulse released before the edge must be ignored.
        #1;
        rst = 1'b0;
        #2;
        check("rst_glitch_mid", sample(), b_f);
        rst = 1'b1;
        drive(d_f);
        @(posedge clk);
        #1;
        check("rst_glitch_edge", sample(), d_f);

        // Reset asserted just after an edge only clears at the following edge.
        rst = 1'b0;
        #2;
        check("rst_late_before_edge", sample(), d_f);
        @(posedge clk);
        #1;
        check("rst_late_at_edge", sample(), zero_f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
